// File: rtl/rr_bus_arb.sv
// Round-robin bus arbiter: one owner at a time, single-cycle turnaround between
// owners, release on request drop, unlocked done, or hold-limit timeout.
module rr_bus_arb #(
  parameter int NUM_REQ  = 4,
  parameter int MAX_HOLD = 16,
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CW  = $clog2(MAX_HOLD)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] lock,
  input  logic               done,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDW-1:0]     grant_idx,
  output logic               grant_vld,
  output logic               timeout
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [CW-1:0]  HOLD_LAST = CW'(MAX_HOLD - 1);
  localparam logic [IDW-1:0] IDX_LAST  = IDW'(NUM_REQ - 1);

  state_t             state;
  logic [IDW-1:0]     ptr;
  logic [CW-1:0]      hold_cnt;

  logic [IDW-1:0]     win_idx;
  logic [NUM_REQ-1:0] win_oh;
  logic               found;
  logic               rel_a, rel_b, rel_c;
  logic [IDW-1:0]     ptr_nxt;

  // First pass searches at or above ptr, second pass wraps to the bottom.
  always_comb begin
    win_idx = '0;
    found   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req[i] && (IDW'(i) >= ptr)) begin
        win_idx = IDW'(i);
        found   = 1'b1;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req[i]) begin
        win_idx = IDW'(i);
        found   = 1'b1;
      end
    end
    win_oh          = '0;
    win_oh[win_idx] = 1'b1;
  end

  // grant_idx doubles as the owner register while BUSY.
  assign rel_a   = !req[grant_idx];
  assign rel_b   = done && !lock[grant_idx];
  assign rel_c   = (hold_cnt == HOLD_LAST);
  assign ptr_nxt = (grant_idx == IDX_LAST) ? '0 : grant_idx + IDW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      hold_cnt  <= '0;
      grant     <= '0;
      grant_idx <= '0;
      grant_vld <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            state     <= BUSY;
            grant     <= win_oh;
            grant_idx <= win_idx;
            grant_vld <= 1'b1;
            hold_cnt  <= '0;
          end
        end
        BUSY: begin
          if (rel_a || rel_b || rel_c) begin
            state     <= IDLE;
            grant     <= '0;
            grant_idx <= '0;
            grant_vld <= 1'b0;
            hold_cnt  <= '0;
            ptr       <= ptr_nxt;
            timeout   <= rel_c && !rel_a && !rel_b;
          end else if (hold_cnt != HOLD_LAST) begin
            hold_cnt <= hold_cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_bus_arb.sv
// Directed, table-driven bench for rr_bus_arb at NUM_REQ=4, MAX_HOLD=8.
module tb_rr_bus_arb;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] lock;
  logic       done;
  logic [3:0] grant;
  logic [1:0] grant_idx;
  logic       grant_vld;
  logic       timeout;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [3:0] req;
    logic [3:0] lock;
    logic       done;
    logic [3:0] g;
    logic [1:0] idx;
    logic       to;
    logic       rst;
  } vec_t;

  vec_t vecs[$];

  rr_bus_arb #(.NUM_REQ(4), .MAX_HOLD(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .lock(lock), .done(done),
    .grant(grant), .grant_idx(grant_idx), .grant_vld(grant_vld), .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int row, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got %0h expected %0h", nm, row, act, exp);
    end
  endtask

  task automatic chk_all(input int row, input logic [3:0] g, input logic [1:0] idx, input logic to);
    chk("grant",     row, {4'b0, grant},     {4'b0, g});
    chk("grant_idx", row, {6'b0, grant_idx}, {6'b0, idx});
    chk("grant_vld", row, {7'b0, grant_vld}, {7'b0, |g});
    chk("timeout",   row, {7'b0, timeout},   {7'b0, to});
  endtask

  task automatic add(input logic [3:0] r, input logic [3:0] l, input logic d,
                     input logic [3:0] g, input logic [1:0] i, input logic to,
                     input logic rs = 1'b0);
    vec_t v;
    v.req = r; v.lock = l; v.done = d; v.g = g; v.idx = i; v.to = to; v.rst = rs;
    vecs.push_back(v);
  endtask

  initial begin
    // Basic grant / drop / regrant, then idle stays idle
    add(4'b0101, 4'b0, 1'b0, 4'b0001, 2'd0, 1'b0);
    add(4'b0100, 4'b0, 1'b0, 4'b0000, 2'd0, 1'b0);
    add(4'b0100, 4'b0, 1'b0, 4'b0100, 2'd2, 1'b0);
    add(4'b0000, 4'b0, 1'b0, 4'b0000, 2'd0, 1'b0);
    add(4'b0000, 4'b0, 1'b0, 4'b0000, 2'd0, 1'b0);
    add(4'b0000, 4'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b1);
    // Full rotation with wrap
    add(4'b1111, 4'b0, 1'b0, 4'b0001, 2'd0, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      add(4'b1111, 4'b0, 1'b1, 4'b0000, 2'd0, 1'b0);
      add(4'b1111, 4'b0, 1'b0, 4'b0001 << (k % 4), 2'(k % 4), 1'b0);
    end
    // Lock keeps owner 1 through done pulses
    add(4'b1111, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0);
    add(4'b1111, 4'b0010, 1'b0, 4'b0010, 2'd1, 1'b0);
    add(4'b1111, 4'b0010, 1'b1, 4'b0010, 2'd1, 1'b0);
    add(4'b1111, 4'b0010, 1'b0, 4'b0010, 2'd1, 1'b0);
    add(4'b1111, 4'b0010, 1'b1, 4'b0010, 2'd1, 1'b0);
    add(4'b1111, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0);
    add(4'b1111, 4'b0000, 1'b0, 4'b0100, 2'd2, 1'b0);
    // Owner 2: done on the hold-limit edge releases without timeout
    for (int k = 0; k < 7; k++) add(4'b1111, 4'b0, 1'b0, 4'b0100, 2'd2, 1'b0);
    add(4'b1111, 4'b0, 1'b1, 4'b0000, 2'd0, 1'b0);
    // Owner 3: pure hold-limit timeout after 8 grant cycles
    add(4'b1000, 4'b0, 1'b0, 4'b1000, 2'd3, 1'b0);
    for (int k = 0; k < 7; k++) add(4'b1000, 4'b0, 1'b0, 4'b1000, 2'd3, 1'b0);
    add(4'b1000, 4'b0, 1'b0, 4'b0000, 2'd0, 1'b1);
    add(4'b1010, 4'b0, 1'b0, 4'b0010, 2'd1, 1'b0);
    // Owner 1: req drop on the hold-limit edge suppresses timeout
    for (int k = 0; k < 7; k++) add(4'b1010, 4'b0, 1'b0, 4'b0010, 2'd1, 1'b0);
    add(4'b1000, 4'b0, 1'b0, 4'b0000, 2'd0, 1'b0);
    add(4'b1000, 4'b0, 1'b0, 4'b1000, 2'd3, 1'b0);

    rst_n = 1'b0; req = '0; lock = '0; done = 1'b0;
    #2;
    chk_all(-1, 4'b0000, 2'd0, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    foreach (vecs[r]) begin
      rst_n = !vecs[r].rst;
      req   = vecs[r].req;
      lock  = vecs[r].lock;
      done  = vecs[r].done;
      @(posedge clk); #1;
      chk_all(r, vecs[r].g, vecs[r].idx, vecs[r].to);
    end

    // Asynchronous reset while owner 3 holds; ptr must restart at 0
    #3;
    rst_n = 1'b0;
    #1;
    chk_all(900, 4'b0000, 2'd0, 1'b0);
    @(posedge clk); #1;
    chk_all(901, 4'b0000, 2'd0, 1'b0);
    rst_n = 1'b1;
    req   = 4'b1001;
    @(posedge clk); #1;
    chk_all(902, 4'b0001, 2'd0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_bus_arb.md
RR_BUS_ARB -- requirements
Module: rr_bus_arb

Interface
REQ-001 The block SHALL provide parameter NUM_REQ, default 4, the number of requesters (legal range 2..16).
REQ-002 The block SHALL provide parameter MAX_HOLD, default 16, the maximum cycles one owner may hold the grant (legal range 2..255).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req  input  NUM_REQ  per-requester bus request, level.
REQ-006 lock  input  NUM_REQ  per-requester "keep grant after done", level; sampled for owner only.
REQ-007 done  input  1  one-cycle pulse from bus: current owner's transfer completed.
REQ-008 grant  output  NUM_REQ  registered one-hot grant; all-zero when no owner.
REQ-009 grant_idx  output  clog2(NUM_REQ)  registered binary index of owner; 0 when no owner.
REQ-010 grant_vld  output  1  registered; high when grant is non-zero.
REQ-011 timeout  output  1  registered one-cycle pulse; owner forcibly released by hold limit.

Function
REQ-012 The FSM SHALL have exactly two states: IDLE (no owner) and BUSY (one owner).
REQ-013 In IDLE with req all-zero, the block SHALL stay in IDLE with grant all-zero.
REQ-014 In IDLE with any req bit set at edge n, the block SHALL enter BUSY and drive grant/grant_idx/grant_vld for the winner from cycle n+1 (1-cycle latency).
REQ-015 Winner selection SHALL be round-robin: lowest set index among req bits at index >= ptr; if none, lowest set index overall.
REQ-016 Pointer ptr (clog2(NUM_REQ) bits) SHALL update only on release, to (owner+1) modulo NUM_REQ; wrap from NUM_REQ-1 to 0.
REQ-017 In BUSY, grant SHALL remain constant until a release event; requests from other requesters SHALL NOT affect grant.
REQ-018 Release events in BUSY, evaluated each edge: (a) req[owner]=0; (b) done=1 and lock[owner]=0; (c) hold counter reaches MAX_HOLD-1.
REQ-019 done=1 with lock[owner]=1 SHALL NOT release; the owner continues holding.
REQ-020 A hold counter SHALL clear to 0 on entry to BUSY and increment by 1 each BUSY cycle without saturating past MAX_HOLD-1.
REQ-021 On any release the block SHALL return to IDLE, driving grant all-zero for exactly one cycle (bus turnaround) before any new grant.
REQ-022 timeout SHALL pulse high for one cycle, coincident with the grant-zero turnaround cycle, only when release is caused solely by (c); (a) or (b) on the same edge takes precedence and suppresses timeout.
REQ-023 The same requester MAY win again after release if it is the only requester; no requester SHALL wait more than NUM_REQ-1 other grants once its req is held high.
REQ-024 grant, grant_idx and grant_vld SHALL always be mutually consistent, with no combinational path from inputs to outputs.

Reset
REQ-025 While rst_n=0: state=IDLE, ptr=0, hold counter=0, grant=0, grant_idx=0, grant_vld=0, timeout=0.
REQ-026 Reset asserted mid-BUSY SHALL drop grant immediately (asynchronously) without a timeout pulse; after deassertion, arbitration SHALL restart from ptr=0.

Verification (NUM_REQ=4, MAX_HOLD=8)
REQ-027 After reset, req=0101 at edge 0 -> grant=0001, grant_idx=0 at cycle 1; req[0] drops -> grant=0000 one cycle, then grant=0100, grant_idx=2.
REQ-028 req=1111 held, done pulsed with lock=0 each grant -> grant sequence 0001,0010,0100,1000,0001, each separated by one zero cycle (wrap check).
REQ-029 Owner 1 with lock[1]=1, done pulsed twice -> grant stays 0010; lock[1]=0 then done -> release, ptr=2.
REQ-030 Owner 3 holds req, no done -> grant held exactly 8 cycles, then grant=0000 with timeout=1 for one cycle; next grant goes to lowest requester from index 0.
REQ-031 Owner 2 with done=1, lock=0 on the same edge the counter reaches 7 -> release with timeout=0.
REQ-032 rst_n pulsed low while grant=1000 -> grant=0000 immediately; after release, req=1001 -> grant=0001.
